// File: rtl/pipeline_arith_pkg.sv
// Shared constants and stage payload layout for the pipelined adder.
package pipeline_arith_pkg;

    localparam int PIPE_STAGES   = 5;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_HALF  = DEFAULT_WIDTH / 2;

    // Payload leaving the low-half add stage at the default width.
    typedef struct packed {
        logic [DEFAULT_HALF-1:0] lo_sum;
        logic                    carry;
        logic [DEFAULT_HALF-1:0] hi_a;
        logic [DEFAULT_HALF-1:0] hi_b;
        logic                    valid;
    } stage_payload_t;

endpackage

// File: rtl/pipeline_arith_stage.sv
// Generic pipeline register: payload plus valid, cleared asynchronously by rst.
module pipeline_arith_stage #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] d,
    input  logic          valid_d,
    output logic [PW-1:0] q,
    output logic          valid_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q       <= '0;
            valid_q <= 1'b0;
        end else begin
            q       <= d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/pipeline_arith.sv
// Five-stage unsigned adder split into half-width adds; one operand pair per cycle.
// Define PIPELINE_ARITH_SAT_EN to clamp overflowing sums to all-ones instead of wrapping.
module pipeline_arith
    import pipeline_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             out_valid
);

    localparam int HALF = WIDTH / 2;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } s1_t;

    // Same layout as stage_payload_t, sized by WIDTH; valid travels beside it.
    typedef struct packed {
        logic [HALF-1:0] lo_sum;
        logic            carry;
        logic [HALF-1:0] hi_a;
        logic [HALF-1:0] hi_b;
    } s2_t;

`ifdef PIPELINE_ARITH_SAT_EN
    typedef struct packed {
        logic             cout;
        logic [WIDTH-1:0] sum;
    } s3_t;
`else
    typedef struct packed {
        logic [WIDTH-1:0] sum;
    } s3_t;
`endif

    logic [PIPE_STAGES:0] valid;
    s1_t                  s1_d, s1_q;
    s2_t                  s2_d, s2_q;
    s3_t                  s3_d, s3_q;
    logic [WIDTH-1:0]     s4_d, s4_q, s5_q;
    logic [HALF:0]        lo_full;

    assign valid[0] = 1'b1;

    always_comb begin
        s1_d.a = a;
        s1_d.b = b;
    end

    assign lo_full = {1'b0, s1_q.a[HALF-1:0]} + {1'b0, s1_q.b[HALF-1:0]};

    always_comb begin
        s2_d.lo_sum = lo_full[HALF-1:0];
        s2_d.carry  = lo_full[HALF];
        s2_d.hi_a   = s1_q.a[WIDTH-1:HALF];
        s2_d.hi_b   = s1_q.b[WIDTH-1:HALF];
    end

`ifdef PIPELINE_ARITH_SAT_EN
    logic [HALF:0] hi_full;
    assign hi_full = {1'b0, s2_q.hi_a} + {1'b0, s2_q.hi_b} + (HALF+1)'(s2_q.carry);

    always_comb begin
        s3_d.cout = hi_full[HALF];
        s3_d.sum  = {hi_full[HALF-1:0], s2_q.lo_sum};
    end

    assign s4_d = s3_q.cout ? '1 : s3_q.sum;
`else
    // Carry out of the high half is dropped, giving modulo 2^WIDTH wrap.
    always_comb begin
        s3_d.sum = {s2_q.hi_a + s2_q.hi_b + HALF'(s2_q.carry), s2_q.lo_sum};
    end

    assign s4_d = s3_q.sum;
`endif

    pipeline_arith_stage #(.PW($bits(s1_t))) u_s1 (
        .clk(clk), .rst(rst), .d(s1_d), .valid_d(valid[0]), .q(s1_q), .valid_q(valid[1])
    );

    pipeline_arith_stage #(.PW($bits(s2_t))) u_s2 (
        .clk(clk), .rst(rst), .d(s2_d), .valid_d(valid[1]), .q(s2_q), .valid_q(valid[2])
    );

    pipeline_arith_stage #(.PW($bits(s3_t))) u_s3 (
        .clk(clk), .rst(rst), .d(s3_d), .valid_d(valid[2]), .q(s3_q), .valid_q(valid[3])
    );

    pipeline_arith_stage #(.PW(WIDTH)) u_s4 (
        .clk(clk), .rst(rst), .d(s4_d), .valid_d(valid[3]), .q(s4_q), .valid_q(valid[4])
    );

    pipeline_arith_stage #(.PW(WIDTH)) u_s5 (
        .clk(clk), .rst(rst), .d(s4_q), .valid_d(valid[4]), .q(s5_q), .valid_q(valid[5])
    );

    assign result    = s5_q;
    assign out_valid = valid[PIPE_STAGES];

endmodule

// File: tb/tb_pipeline_arith.sv
// Bench for pipeline_arith: queue-based latency model plus directed literal checks.
module tb_pipeline_arith;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] result;
    logic       out_valid;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int a;
        int b;
    } pair_t;

    pair_t hist[$];

    pipeline_arith #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .a(a),
        .b(b),
        .result(result),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_sum(input int x, input int y);
        int s;
        s = x + y;
`ifdef PIPELINE_ARITH_SAT_EN
        if (s > 255) s = 255;
`else
        s = s % 256;
`endif
        return 8'(s);
    endfunction

    // Every edge with rst low samples one pair; the pair sampled five edges ago is on result.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hist.delete();
        end else begin
            hist.push_back('{a: int'(a), b: int'(b)});
            if (hist.size() > 5) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin
        logic [7:0] exp_r;
        logic       exp_v;
        if (hist.size() >= 5) begin
            exp_v = 1'b1;
            exp_r = model_sum(hist[hist.size()-5].a, hist[hist.size()-5].b);
        end else begin
            exp_v = 1'b0;
            exp_r = 8'd0;
        end
        total++;
        if (result !== exp_r || out_valid !== exp_v) begin
            bad++;
            $display("FAIL stream t=%0t result=%0d/%0b want=%0d/%0b", $time, result, out_valid, exp_r, exp_v);
        end
    end

    task automatic check(input string name, input logic [7:0] exp_r, input logic exp_v);
        total++;
        if (result !== exp_r || out_valid !== exp_v) begin
            bad++;
            $display("FAIL %s result=%0d valid=%0b want result=%0d valid=%0b", name, result, out_valid, exp_r, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold_pair(input logic [7:0] x, input logic [7:0] y);
        a = x;
        b = y;
        tick(6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] sat_200_100;
        logic [7:0] sat_255_1;
`ifdef PIPELINE_ARITH_SAT_EN
        sat_200_100 = 8'd255;
        sat_255_1   = 8'd255;
`else
        sat_200_100 = 8'd44;
        sat_255_1   = 8'd0;
`endif
        rst = 1'b1;
        a   = 8'd0;
        b   = 8'd0;
        #1;
        check("reset_state", 8'd0, 1'b0);
        tick(2);

        a   = 8'd10;
        b   = 8'd15;
        rst = 1'b0;
        tick(4);
        check("first_edge4", 8'd0, 1'b0);
        tick(1);
        check("first_edge5", 8'd25, 1'b1);
        tick(1);
        check("first_edge6", 8'd25, 1'b1);

        hold_pair(8'd20, 8'd5);   check("seq_20_5",  8'd25,  1'b1);
        hold_pair(8'd30, 8'd40);  check("seq_30_40", 8'd70,  1'b1);
        hold_pair(8'd50, 8'd60);  check("seq_50_60", 8'd110, 1'b1);
        hold_pair(8'd70, 8'd80);  check("seq_70_80", 8'd150, 1'b1);

        a = 8'd1; b = 8'd2; tick(1);
        a = 8'd3; b = 8'd4; tick(1);
        a = 8'd5; b = 8'd6; tick(1);
        a = 8'd0; b = 8'd0; tick(2);
        check("b2b_first",  8'd3,  1'b1);
        tick(1);
        check("b2b_second", 8'd7,  1'b1);
        tick(1);
        check("b2b_third",  8'd11, 1'b1);

        hold_pair(8'd200, 8'd100); check("ovf_200_100", sat_200_100, 1'b1);
        hold_pair(8'd255, 8'd1);   check("ovf_255_1",   sat_255_1,   1'b1);
        hold_pair(8'd15,  8'd1);   check("nibble_carry", 8'd16,      1'b1);
        hold_pair(8'd255, 8'd0);   check("max_plus_0",   8'd255,     1'b1);

        for (int i = 0; i < 200; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) begin
                a = 8'hff;
                b = 8'($urandom_range(0, 3));
            end
            tick(1);
        end

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 8; i++) begin
                a = 8'($urandom_range(1, 255));
                b = 8'($urandom_range(0, 255));
                tick(1);
            end
            #2;
            rst = 1'b1;
            #1;
            check("async_reset", 8'd0, 1'b0);
            tick(1 + r);
            a   = 8'($urandom_range(1, 255));
            b   = 8'($urandom_range(0, 255));
            rst = 1'b0;
            tick(4);
            check("post_reset_edge4", 8'd0, 1'b0);
            for (int i = 0; i < 10; i++) begin
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                tick(1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_arith.md
PIPELINE_ARITH -- requirements
Module: pipeline_arith

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand and result width (even, at least 2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port: a  input  WIDTH  unsigned operand A, sampled every cycle.
REQ-005 SHALL have port: b  input  WIDTH  unsigned operand B, sampled every cycle.
REQ-006 SHALL have port: result  output  WIDTH  registered sum, driven directly from a flop.
REQ-007 SHALL have port: out_valid  output  1  high when result holds a sum of operands sampled after reset release; may be left unconnected.

Function
REQ-008 SHALL compute result = a + b, unsigned, truncated to WIDTH bits (wrap-around) when SAT_EN is not defined.
REQ-009 SHALL be a 5-register-stage pipeline: operands sampled at rising edge k appear on result after rising edge k+4, and stay stable until edge k+5.
REQ-010 SHALL accept one new operand pair every cycle (throughput 1/cycle), with no stalls or handshake.
REQ-011 SHALL use these stages: S1 registers a and b; S2 adds the low halves and registers the low sum and carry; S3 adds the high halves plus carry; S4 performs the overflow/saturation decision; S5 is the output register.
REQ-012 SHALL propagate a valid bit alongside the data through all 5 stages; the valid bit enters S1 as 1 whenever rst is low.
REQ-013 SHALL compute result from registered pipeline state only, with no combinational path from a/b to result.
REQ-014 SHALL, for constant inputs held for 5 or more cycles, hold result constant at that sum.
REQ-015 SHALL keep each input change independent: stages never mix operands from different cycles.

Reset
REQ-016 SHALL clear all pipeline registers, result and out_valid to 0 immediately when rst asserts, without waiting for a clock edge.
REQ-017 SHALL, on reset mid-operation, discard all in-flight operations; no sum sampled before the reset is ever presented.
REQ-018 SHALL sample the first operands at the first rising edge with rst low; out_valid rises after the 5th such edge.

Configuration
REQ-019 SHALL gate saturation with macro PIPELINE_ARITH_SAT_EN: when defined, S4 clamps a sum with carry-out to all-ones (255 for WIDTH=8); when undefined, the sum wraps modulo 2^WIDTH.
REQ-020 SHALL keep latency and reset behaviour identical with and without PIPELINE_ARITH_SAT_EN.

Structure
REQ-021 SHALL place the constants PIPE_STAGES = 5 and DEFAULT_WIDTH = 8, and the stage-payload struct typedef (low sum, carry, high operands, valid), in package pipeline_arith_pkg.
REQ-022 SHALL use one sub-module, pipeline_arith_stage: a generic async-reset register stage for payload plus valid, instantiated once per stage.

Verification
REQ-023 SHALL cover: reset asserted, a=10, b=15, release, hold 6 cycles -> result=25 from edge 5 on; out_valid=0 before edge 5 and 1 from edge 5 on.
REQ-024 SHALL cover: sequence (20,5), (30,40), (50,60), (70,80), each held 6 cycles -> result 25, 70, 110, 150 respectively.
REQ-025 SHALL cover: back-to-back inputs one per cycle, (1,2), (3,4), (5,6) -> result 3, 7, 11 on consecutive cycles starting 5 edges after the first sample.
REQ-026 SHALL cover: a=200, b=100 -> result=44 with PIPELINE_ARITH_SAT_EN undefined, result=255 with it defined.
REQ-027 SHALL cover: a=255, b=1 -> result=0 without the macro; checks carry across the nibble boundary (a=15, b=1 -> 16).
REQ-028 SHALL cover: rst pulsed asynchronously between edges while the pipeline is full -> result=0 and out_valid=0 immediately; after release, result holds no stale value before the new 5-cycle latency elapses.
